// File: rtl/singcyc_data_mem_resp.sv
// singcyc_data_mem_resp: word RAM plus memory-mapped timer, LED, switch and systick for the core's data port
module singcyc_data_mem_resp #(
  parameter int          RAM_WORDS   = 256,
  parameter logic [31:0] PERIPH_BASE = 32'h4000_0000,
  parameter int          LED_W       = 8,
  parameter int          SW_W        = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [31:0]      iAddr,
  input  logic             iMemRead,
  input  logic             iMemWrite,
  input  logic [31:0]      iWrData,
  output logic [31:0]      oRdData,
  input  logic [SW_W-1:0]  iSwitch,
  output logic [LED_W-1:0] oLed,
  output logic             oIrq
);
  localparam int AW = $clog2(RAM_WORDS);
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] th, tl, sysTick, rdWord;
  logic [29:0] off;
  logic [2:0] tcon, sel;
  logic [SW_W-1:0] swMeta, swSync;
  logic [LED_W-1:0] led;
  logic isRam, inWin, ovf, irqSet, wrPer;
  assign isRam = iAddr < 32'(RAM_WORDS * 4);
  assign off = iAddr[31:2] - PERIPH_BASE[31:2];
  assign inWin = off[29:3] == '0;
  assign sel = off[2:0];
  assign wrPer = iMemWrite && inWin;
  assign ovf = tcon[0] && tl == 32'hFFFF_FFFF;
  // a reload with irq enabled must survive a same-cycle software write to TCON
  assign irqSet = ovf && tcon[1];
  always_comb begin
    rdWord = isRam ? ram[iAddr[AW+1:2]] :
             !inWin ? '0 :
             sel == 3'd0 ? th :
             sel == 3'd1 ? tl :
             sel == 3'd2 ? 32'(tcon) :
             sel == 3'd3 ? 32'(led) :
             sel == 3'd4 ? 32'(swSync) :
             sel == 3'd5 ? sysTick : '0;
  end
  assign oRdData = iMemRead ? rdWord : '0;
  assign oLed = led;
  assign oIrq = tcon[2] && tcon[1];
  always_ff @(posedge iClk)
    if (!iRst && iMemWrite && isRam) ram[iAddr[AW+1:2]] <= iWrData;
  always_ff @(posedge iClk) begin
    if (iRst) begin
      th <= '0;
      tl <= '0;
      tcon <= '0;
      led <= '0;
      sysTick <= '0;
      swMeta <= '0;
      swSync <= '0;
    end else begin
      th <= wrPer && sel == 3'd0 ? iWrData : th;
      tl <= wrPer && sel == 3'd1 ? iWrData : ovf ? th : tl + 32'(tcon[0]);
      tcon <= wrPer && sel == 3'd2 ? {iWrData[2] | irqSet, iWrData[1:0]} : {tcon[2] | irqSet, tcon[1:0]};
      led <= wrPer && sel == 3'd3 ? iWrData[LED_W-1:0] : led;
      sysTick <= sysTick + 32'd1;
      swMeta <= iSwitch;
      swSync <= swMeta;
    end
  end
endmodule

// File: tb/tb_singcyc_data_mem_resp.sv
// tb_singcyc_data_mem_resp: directed checks of RAM, timer, irq races, peripherals and reset
module tb_singcyc_data_mem_resp;
  localparam logic [31:0] P = 32'h4000_0000;
  localparam logic [31:0] A_TH = P, A_TL = P + 32'h4, A_TCON = P + 32'h8, A_LED = P + 32'hC;
  localparam logic [31:0] A_SW = P + 32'h10, A_ST = P + 32'h14;
  logic iClk = 0, iRst = 1, iMemRead = 0, iMemWrite = 0, oIrq;
  logic [31:0] iAddr = 0, iWrData = 0, oRdData;
  logic [7:0] iSwitch = 0, oLed;
  int checks = 0, errors = 0;
  singcyc_data_mem_resp dut (
    .iClk(iClk), .iRst(iRst), .iAddr(iAddr), .iMemRead(iMemRead), .iMemWrite(iMemWrite),
    .iWrData(iWrData), .oRdData(oRdData), .iSwitch(iSwitch), .oLed(oLed), .oIrq(oIrq)
  );
  always #5 iClk = ~iClk;
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    iAddr = a; iWrData = d; iMemWrite = 1; iMemRead = 0;
    tick();
    iMemWrite = 0;
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    iAddr = a; iMemRead = 1; iMemWrite = 0;
    #1;
    chk(tag, oRdData, exp);
    tick();
    iMemRead = 0;
  endtask
  initial begin
    repeat (2) @(posedge iClk);
    #1;
    iRst = 0;
    chk("rst_led", 32'(oLed), 0);
    chk("rst_irq", 32'(oIrq), 0);
    rd("rst_systick", A_ST, 0);
    wr(32'h14, 32'h1234_5678);
    wr(32'h10, 32'hDEAD_BEEF);
    rd("ram_10", 32'h10, 32'hDEAD_BEEF);
    rd("ram_13", 32'h13, 32'hDEAD_BEEF);
    rd("ram_14", 32'h14, 32'h1234_5678);
    wr(A_TH, 32'hFFFF_FFFD);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 3);
    chk("t2_irq_pre", 32'(oIrq), 0);
    rd("t2_tl0", A_TL, 32'hFFFF_FFFE);
    chk("t2_irq_mid", 32'(oIrq), 0);
    rd("t2_tl1", A_TL, 32'hFFFF_FFFF);
    rd("t2_tl2", A_TL, 32'hFFFF_FFFD);
    chk("t2_irq", 32'(oIrq), 1);
    rd("t2_tcon", A_TCON, 7);
    wr(A_TCON, 0);
    wr(A_TH, 0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 3);
    tick();
    wr(A_TCON, 3);
    chk("t3a_irq", 32'(oIrq), 1);
    rd("t3a_tcon", A_TCON, 7);
    wr(A_TCON, 0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 3);
    tick();
    tick();
    chk("t3b_irq_set", 32'(oIrq), 1);
    wr(A_TCON, 3);
    rd("t3b_tcon", A_TCON, 3);
    chk("t3b_irq_clr", 32'(oIrq), 0);
    wr(A_TCON, 0);
    wr(A_LED, 32'hA5);
    chk("led", 32'(oLed), 32'hA5);
    iAddr = A_LED; iMemRead = 0;
    #1;
    chk("noread_zero", oRdData, 0);
    iSwitch = 8'h3C;
    tick();
    rd("sw_lag1", A_SW, 0);
    rd("sw_lag2", A_SW, 32'h3C);
    wr(A_SW, 32'hFF);
    rd("sw_ro", A_SW, 32'h3C);
    rd("unmap_rd", P + 32'h18, 0);
    wr(P + 32'h18, 32'h123);
    rd("unmap_wr", P + 32'h18, 0);
    wr(32'h0, 32'h1111_1111);
    wr(32'h400, 32'h2222_2222);
    rd("ram_end", 32'h400, 0);
    rd("ram_alias", 32'h0, 32'h1111_1111);
    wr(A_TL, 32'h55);
    iAddr = A_TL; iWrData = 32'h66; iMemRead = 1; iMemWrite = 1;
    #1;
    chk("rw_old", oRdData, 32'h55);
    tick();
    iMemRead = 0; iMemWrite = 0;
    rd("rw_new", A_TL, 32'h66);
    wr(32'h20, 32'hCAFE_0000);
    wr(A_LED, 32'hFF);
    wr(A_TCON, 7);
    chk("t6_irq_pre", 32'(oIrq), 1);
    chk("t6_led_pre", 32'(oLed), 32'hFF);
    iRst = 1; iAddr = 32'h20; iWrData = 32'hBAD; iMemWrite = 1;
    tick();
    iRst = 0; iMemWrite = 0;
    chk("t6_led", 32'(oLed), 0);
    chk("t6_irq", 32'(oIrq), 0);
    rd("t6_systick0", A_ST, 0);
    rd("t6_sw", A_SW, 0);
    rd("t6_tl", A_TL, 0);
    rd("t6_th", A_TH, 0);
    rd("t6_tcon", A_TCON, 0);
    rd("t6_ram", 32'h20, 32'hCAFE_0000);
    wr(A_ST, 32'h1234);
    rd("t6_systick7", A_ST, 7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
